// File: rtl/psum_lif_spike_packer.sv
// Multi-step LIF neuron on biased partial sums; packs spike nibbles into wide words for the spike RAM.
// Latency: a write strobe appears TIME_STEPS+1 cycles after the valid of the element that completes a word.
// Backpressure: none; accepts one element per cycle in S_RUN/S_DRAIN and ignores input in S_FLUSH/S_DONE.
module psum_lif_spike_packer #(
    parameter int TIME_STEPS = 4,
    parameter int P_WIDTH    = 20,
    parameter int PSUM_WIDTH = TIME_STEPS * P_WIDTH,
    parameter int VTH        = 256,
    parameter int PACK_NUM   = 16,
    parameter int OUT_WIDTH  = PACK_NUM * TIME_STEPS,
    parameter int ADDR_WIDTH = 12,
    parameter int DRAIN_IDLE = 8
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic [PSUM_WIDTH-1:0] i_PsumData,
    input  logic                  i_PsumValid,
    input  logic                  i_Psum_Finish,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [OUT_WIDTH-1:0]  o_wr_data,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int CNT_W  = $clog2(PACK_NUM);
    localparam int IDLE_W = $clog2(DRAIN_IDLE) + 1;
    localparam logic signed [P_WIDTH:0] VTH_S = (P_WIDTH+1)'(VTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t r_state, w_state_nxt;
    logic [IDLE_W-1:0] r_idle;

    // Pipeline state: one entry per time step
    logic [TIME_STEPS-1:0] r_vld;
    logic [P_WIDTH:0]      r_v     [TIME_STEPS];
    logic [TIME_STEPS-1:0] r_nib   [TIME_STEPS];
    logic [PSUM_WIDTH-1:0] r_lanes [TIME_STEPS];

    logic [TIME_STEPS-1:0] w_vin;
    logic [TIME_STEPS-1:0] w_spk;
    logic [PSUM_WIDTH-1:0] w_lin   [TIME_STEPS];
    logic [P_WIDTH:0]      w_vprev [TIME_STEPS];
    logic [P_WIDTH:0]      w_h     [TIME_STEPS];
    logic [TIME_STEPS-1:0] w_nin   [TIME_STEPS];

    logic [CNT_W-1:0]      r_cnt;
    logic [OUT_WIDTH-1:0]  r_buf;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_in_vld, w_act, w_pk_vld, w_full, w_flush;
    logic [OUT_WIDTH-1:0]  w_buf_new;

    // H = V + ((X - V) >>> 1); difference kept two bits wider so the halving never overflows
    function automatic logic [P_WIDTH:0] f_h(input logic [P_WIDTH-1:0] x, input logic [P_WIDTH:0] v);
        logic signed [P_WIDTH+1:0] d;
        d = $signed({{2{x[P_WIDTH-1]}}, x}) - $signed({v[P_WIDTH], v});
        d = d >>> 1;
        return v + d[P_WIDTH:0];
    endfunction

    assign w_in_vld = i_PsumValid && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_act    = w_in_vld || (|r_vld);

    // Per-stage neuron update: stage 0 starts from the input with V=0, later stages from the previous register
    always_comb begin
        w_vin[0]   = w_in_vld;
        w_lin[0]   = i_PsumData;
        w_vprev[0] = '0;
        w_nin[0]   = '0;
        for (int t = 1; t < TIME_STEPS; t++) begin
            w_vin[t]   = r_vld[t-1];
            w_lin[t]   = r_lanes[t-1];
            w_vprev[t] = r_v[t-1];
            w_nin[t]   = r_nib[t-1];
        end
        for (int t = 0; t < TIME_STEPS; t++) begin
            w_h[t]   = f_h(w_lin[t][P_WIDTH*t +: P_WIDTH], w_vprev[t]);
            w_spk[t] = ($signed(w_h[t]) >= VTH_S);
        end
    end

    // Pipeline registers; a firing neuron resets its membrane to zero
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_vld <= '0;
            for (int t = 0; t < TIME_STEPS; t++) begin
                r_v[t]     <= '0;
                r_nib[t]   <= '0;
                r_lanes[t] <= '0;
            end
        end else begin
            r_vld <= w_vin;
            for (int t = 0; t < TIME_STEPS; t++) begin
                if (w_vin[t]) begin
                    r_lanes[t] <= w_lin[t];
                    r_v[t]     <= w_spk[t] ? '0 : w_h[t];
                    r_nib[t]   <= w_nin[t] | ({{(TIME_STEPS-1){1'b0}}, w_spk[t]} << t);
                end
            end
        end
    end

    assign w_pk_vld  = r_vld[TIME_STEPS-1];
    assign w_full    = w_pk_vld && (r_cnt == CNT_W'(PACK_NUM-1));
    assign w_flush   = (r_state == S_FLUSH);
    assign w_buf_new = r_buf | (OUT_WIDTH'(r_nib[TIME_STEPS-1]) << (TIME_STEPS * r_cnt));

    // Pack nibbles into the word buffer and write it when full or on flush
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt     <= '0;
            r_buf     <= '0;
            r_addr    <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= w_full || w_flush;
            if (w_full || w_flush) begin
                o_wr_data <= w_flush ? r_buf : w_buf_new;
                o_wr_addr <= r_addr;
                r_addr    <= r_addr + 1'b1;
                r_buf     <= '0;
                r_cnt     <= '0;
            end else if (w_pk_vld) begin
                r_buf <= w_buf_new;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Control state, drain idle counter and sticky status flags
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= S_RUN;
            r_idle  <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_DRAIN) && !w_act) r_idle <= r_idle + 1'b1;
            else                                r_idle <= '0;
            o_done  <= (w_state_nxt == S_DONE);
            o_err   <= o_err || ((r_state == S_DONE) && i_PsumValid);
        end
    end

    // Next state: leave S_DRAIN only after a quiet window so no in-flight element is lost
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (i_Psum_Finish) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_act && (r_idle == IDLE_W'(DRAIN_IDLE-1)))
                         w_state_nxt = (r_cnt != '0) ? S_FLUSH : S_DONE;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_psum_lif_spike_packer.sv
// Bench for psum_lif_spike_packer: behavioural neuron/packer model plus a per-cycle output compare.
// Latency modelled from the element valid cycle; flush/done timing from the last valid cycle.
// Input is never backpressured, so the bench drives freely and only predicts outputs.
module tb_psum_lif_spike_packer;

    localparam int NEVER = 32'h7fff_ffff;

    logic        s_clk = 1'b0;
    logic        s_rst_n = 1'b1;
    logic [79:0] i_PsumData = '0;
    logic        i_PsumValid = 1'b0;
    logic        i_Psum_Finish = 1'b0;
    logic        o_wr_en;
    logic [11:0] o_wr_addr;
    logic [63:0] o_wr_data;
    logic        o_done;
    logic        o_err;

    psum_lif_spike_packer dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n),
        .i_PsumData(i_PsumData), .i_PsumValid(i_PsumValid), .i_Psum_Finish(i_Psum_Finish),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;
    wr_t q[$];

    int          m_k, m_last, done_due, err_due, last_cyc;
    logic [63:0] m_word, last_data;
    logic [11:0] m_addr, last_addr;
    bit          m_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor of d/2 written out explicitly for negative values
    function automatic int half_floor(input int d);
        if (d >= 0) return d / 2;
        return -((-d + 1) / 2);
    endfunction

    // Reference LIF over all time steps of one element
    function automatic logic [3:0] model_nib(input logic [79:0] d);
        int v, x, h;
        logic [3:0] n;
        v = 0;
        n = '0;
        for (int t = 0; t < 4; t++) begin
            x = $signed(d[20*t +: 20]);
            h = v + half_floor(x - v);
            if (h >= 256) begin
                n[t] = 1'b1;
                v = 0;
            end else begin
                v = h;
            end
        end
        return n;
    endfunction

    function automatic logic [79:0] lanes(input int val);
        logic [19:0] l;
        l = val[19:0];
        return {l, l, l, l};
    endfunction

    task automatic model_clear();
        q.delete();
        m_k = 0; m_word = '0; m_addr = '0; m_done = 0; m_last = 0;
        done_due = NEVER; err_due = NEVER;
    endtask

    task automatic model_accept(input logic [79:0] d);
        wr_t w;
        if (m_done) begin
            if (err_due == NEVER) err_due = cyc + 1;
            return;
        end
        m_word = m_word | (64'(model_nib(d)) << (4 * m_k));
        m_k++;
        m_last = cyc;
        if (m_k == 16) begin
            w.due = cyc + 5; w.addr = m_addr; w.data = m_word;
            q.push_back(w);
            m_addr++;
            m_k = 0;
            m_word = '0;
        end
    endtask

    task automatic send(input logic [79:0] d);
        @(posedge s_clk); #1;
        i_PsumValid = 1'b1;
        i_PsumData  = d;
        model_accept(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge s_clk); #1;
            i_PsumValid = 1'b0;
        end
    endtask

    // Predict drain: last activity at m_last+4, eight quiet cycles, then flush or done
    task automatic finish_drain();
        wr_t w;
        if (m_k > 0) begin
            w.due = m_last + 14; w.addr = m_addr; w.data = m_word;
            q.push_back(w);
            m_addr++;
            m_k = 0;
            m_word = '0;
            done_due = m_last + 14;
        end else begin
            done_due = m_last + 13;
        end
        while (cyc < done_due + 3) begin
            @(posedge s_clk); #1;
            i_PsumValid   = 1'b0;
            i_Psum_Finish = 1'b1;
        end
        m_done = 1;
    endtask

    task automatic do_reset();
        @(posedge s_clk); #1;
        s_rst_n       = 1'b0;
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
        model_clear();
        #1;
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        repeat (2) @(posedge s_clk);
        #1 s_rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model's scheduled writes and status
    always @(negedge s_clk) begin : cmp
        bit exp_en;
        if (s_rst_n) begin
            exp_en = (q.size() > 0) && (q[0].due == cyc);
            chk("wr_en", o_wr_en, exp_en);
            if (o_wr_en) begin
                last_data = o_wr_data;
                last_addr = o_wr_addr;
                last_cyc  = cyc;
            end
            if (exp_en) begin
                chk("wr_addr", o_wr_addr, q[0].addr);
                chk("wr_data", o_wr_data, q[0].data);
                void'(q.pop_front());
            end else if ((q.size() > 0) && (q[0].due < cyc)) begin
                void'(q.pop_front());
            end
            chk("done", o_done, cyc >= done_due);
            chk("err", o_err, cyc >= err_due);
        end
    end

    initial begin : main
        logic [79:0] d;
        int          t16, r;
        model_clear();
        last_data = '0; last_addr = '0; last_cyc = 0;

        // Model pins from hand-worked values
        chk("model_600", model_nib(lanes(600)), 4'b1111);
        chk("model_300", model_nib(lanes(300)), 4'b0100);
        chk("model_m1", model_nib(lanes(-1)), 4'b0000);
        chk("model_256", model_nib(lanes(512)), 4'b1111);

        // 1: sixteen all-spiking elements
        do_reset();
        t16 = 0;
        for (int i = 0; i < 16; i++) begin
            send(lanes(600));
            t16 = cyc;
        end
        idle(8);
        chk("t1_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_addr", last_addr, 0);
        chk("t1_lat", last_cyc, t16 + 5);

        // 2: mixed 300 / -1 / 600 elements
        for (int i = 0; i < 16; i++)
            send(lanes((i % 3 == 0) ? 300 : (i % 3 == 1) ? -1 : 600));
        idle(8);
        chk("t2_addr", last_addr, 1);

        // 3: 256 random elements back-to-back
        do_reset();
        for (int i = 0; i < 256; i++) begin
            for (int t = 0; t < 4; t++) begin
                r = int'($urandom_range(0, 524288)) - 262144;
                d[20*t +: 20] = r[19:0];
            end
            send(d);
        end
        idle(8);
        chk("t3_last_addr", last_addr, 15);

        // 4: twenty elements, finish raised before the last two; partial word flushed
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 18) i_Psum_Finish = 1'b1;
            send(lanes(600));
        end
        finish_drain();
        chk("t4_flush_data", last_data, 64'h0000_0000_0000_FFFF);
        chk("t4_flush_addr", last_addr, 1);
        chk("t4_done", o_done, 1);

        // 5: exactly two words, no flush; late valid raises the error flag
        do_reset();
        for (int i = 0; i < 32; i++) send(lanes(600));
        finish_drain();
        chk("t5_last_addr", last_addr, 1);
        send(lanes(600));
        idle(6);
        chk("t5_err", o_err, 1);
        chk("t5_done", o_done, 1);

        // 6: reset mid-word discards the partial word
        do_reset();
        for (int i = 0; i < 10; i++) send(lanes(600));
        do_reset();
        for (int i = 0; i < 16; i++) send(lanes(300));
        idle(10);
        chk("t6_data", last_data, 64'h4444_4444_4444_4444);
        chk("t6_addr", last_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
